// File: rtl/rvm_operand_fetch.sv
// Operand fetch for the add/sub/compare unit: sequences rs1/rs2 reads through one
// synchronous RF read port. Define RVM_FETCH_X0_SKIP_EN to suppress x0 reads.
module rvm_operand_fetch #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_use_imm,
  input  logic [2:0]        req_op,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [31:0]       rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_lhs,
  output logic [31:0]       out_rhs,
  output logic [2:0]        out_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RS1,
    S_RS2,
    S_CAP,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [31:0]       imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [2:0]        op_q, op_d;
  logic              rd_en_q, rd_en_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       lhs_q, lhs_d;
  logic [31:0]       rhs_q, rhs_d;
  logic [2:0]        out_op_q, out_op_d;

  // Skip flags: read cycle keeps its slot, but the strobe is withheld and the operand forced to zero.
  logic req_rs1_skip, rs1_skip, rs2_skip;
`ifdef RVM_FETCH_X0_SKIP_EN
  assign req_rs1_skip = (req_rs1 == '0);
  assign rs1_skip     = (rs1_q == '0);
  assign rs2_skip     = (rs2_q == '0);
`else
  assign req_rs1_skip = 1'b0;
  assign rs1_skip     = 1'b0;
  assign rs2_skip     = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    op_d      = op_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    out_op_d  = out_op_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          imm_d     = req_imm;
          use_imm_d = req_use_imm;
          op_d      = req_op;
          state_d   = S_RS1;
          // Strobe is registered, so the rs1 read is launched on the accept edge.
          if (!req_rs1_skip) begin
            rd_en_d   = 1'b1;
            rd_addr_d = req_rs1;
          end
        end
      end
      S_RS1: begin
        state_d = S_RS2;
        if (!use_imm_q && !rs2_skip) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rs2_q;
        end
      end
      S_RS2: begin
        lhs_d = rs1_skip ? 32'h0 : rf_rd_data;
        if (use_imm_q) begin
          rhs_d    = imm_q;
          out_op_d = op_q;
          state_d  = S_OUT;
        end else begin
          state_d  = S_CAP;
        end
      end
      S_CAP: begin
        rhs_d    = rs2_skip ? 32'h0 : rf_rd_data;
        out_op_d = op_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      op_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      out_op_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      op_q      <= op_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      out_op_q  <= out_op_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign rf_rd_en   = rd_en_q;
  assign rf_rd_addr = rd_addr_q;
  assign out_lhs    = lhs_q;
  assign out_rhs    = rhs_q;
  assign out_op     = out_op_q;

endmodule

// File: tb/tb_rvm_operand_fetch.sv
// Self-checking bench for rvm_operand_fetch: directed table, hand-written reset
// sequence and randomized requests against a register-file/operand reference model.
module tb_rvm_operand_fetch;

  localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_LTU = 3'd6;
`ifdef RVM_FETCH_X0_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        req_use_imm = 1'b0;
  logic [2:0]  req_op = '0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_lhs, out_rhs;
  logic [2:0]  out_op;

  rvm_operand_fetch #(.REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_use_imm(req_use_imm), .req_op(req_op),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lhs(out_lhs), .out_rhs(out_rhs), .out_op(out_op)
  );

  always #5 clk = ~clk;

  // Register file model: data one cycle after the strobe, garbage when no strobe.
  logic [31:0] rf [32];
  always @(posedge clk) rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : 32'hDEAD_BEEF;

  int cyc = 0;
  int rd_addr_log[$];
  int rd_cyc_log[$];
  always @(posedge clk) begin
    if (rf_rd_en && !reset) begin
      rd_addr_log.push_back(int'(rf_rd_addr));
      rd_cyc_log.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: accept, latency, operands, read trace, OUT hold, handshake.
  task automatic run_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic use_imm, input logic [2:0] op, input int hold,
                         input logic [31:0] exp_lhs, input logic [31:0] exp_rhs,
                         input int exp_lat, input string tag);
    int n;
    int base;
    int exp_reads[$];
    @(negedge clk);
    check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_use_imm = use_imm; req_op = op;
    req_valid = 1'b1;
    base = rd_addr_log.size();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " lhs"}, out_lhs, exp_lhs);
    check({tag, " rhs"}, out_rhs, exp_rhs);
    check({tag, " op"}, 32'(out_op), 32'(op));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom);
      req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_imm = $urandom; req_use_imm = 1'($urandom); req_op = 3'($urandom);
      @(negedge clk);
      check({tag, " hold_flags"}, {29'd0, out_valid, req_ready, 1'b0}, 32'b100);
      check({tag, " hold_lhs"}, out_lhs, exp_lhs);
      check({tag, " hold_rhs"}, out_rhs, exp_rhs);
      check({tag, " hold_op"}, 32'(out_op), 32'(op));
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " release"}, {30'd0, out_valid, req_ready}, 32'b01);
    if (!(SKIP && rs1 == 5'd0)) exp_reads.push_back(int'(rs1));
    if (!use_imm && !(SKIP && rs2 == 5'd0)) exp_reads.push_back(int'(rs2));
    check({tag, " read_count"}, 32'(rd_addr_log.size() - base), 32'(exp_reads.size()));
    for (int i = 0; i < exp_reads.size() && base + i < rd_addr_log.size(); i++)
      check({tag, " read_addr"}, 32'(rd_addr_log[base + i]), 32'(exp_reads[i]));
    if (exp_reads.size() == 2 && rd_addr_log.size() - base == 2)
      check({tag, " read_gap"}, 32'(rd_cyc_log[base + 1] - rd_cyc_log[base]), 32'd1);
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  op;
    int          hold;
    logic [31:0] exp_lhs;
    logic [31:0] exp_rhs;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [4:0]  r1, r2;
    logic [31:0] im, el, er;
    logic        ui;

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    rf[2] = 32'h2222_0002;
    rf[5] = 32'h0000_0010;
    rf[6] = 32'hFFFF_FFF0;
    rf[7] = 32'h1234_5678;
    rf[9] = 32'hA5A5_A5A5;

    vecs[0] = '{5'd5, 5'd6, 32'h0,         1'b0, OP_ADD, 0,  32'h0000_0010, 32'hFFFF_FFF0, 4, "rr_add"};
    vecs[1] = '{5'd7, 5'd0, 32'hFFFF_F800, 1'b1, OP_SUB, 0,  32'h1234_5678, 32'hFFFF_F800, 3, "ri_sub"};
    vecs[2] = '{5'd5, 5'd6, 32'h0,         1'b0, OP_ADD, 10, 32'h0000_0010, 32'hFFFF_FFF0, 4, "hold10"};
    vecs[3] = '{5'd9, 5'd9, 32'h0,         1'b0, OP_LTU, 0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 4, "same_reg"};
    vecs[4] = '{5'd0, 5'd2, 32'h0,         1'b0, OP_ADD, 0,  32'h0,         32'h2222_0002, 4, "x0_lhs"};
    vecs[5] = '{5'd7, 5'd9, 32'h0,         1'b0, OP_NOP, 1,  32'h1234_5678, 32'hA5A5_A5A5, 4, "nop_fwd"};

    repeat (2) @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst rd_en", 32'(rf_rd_en), 32'd0);
    check("rst rd_addr", 32'(rf_rd_addr), 32'd0);
    check("rst lhs", out_lhs, 32'd0);
    check("rst rhs", out_rhs, 32'd0);
    check("rst op", 32'(out_op), 32'd0);
    reset = 1'b0;

    // Reset asserted while the rs2 read is in flight.
    @(negedge clk);
    req_rs1 = 5'd3; req_rs2 = 5'd4; req_use_imm = 1'b0; req_op = OP_ADD; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst rd_en_before", 32'(rf_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst rd_en", 32'(rf_rd_en), 32'd0);
    check("midrst ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst ready", 32'(req_ready), 32'd1);
    check("postrst out_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i])
      run_req(vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].use_imm, vecs[i].op, vecs[i].hold,
              vecs[i].exp_lhs, vecs[i].exp_rhs, vecs[i].exp_lat, vecs[i].name);

    for (int k = 0; k < 40; k++) begin
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      if ($urandom_range(0, 7) == 0) r1 = 5'd0;
      if ($urandom_range(0, 7) == 0) r2 = r1;
      im = $urandom;
      ui = 1'($urandom);
      el = (SKIP && r1 == 5'd0) ? 32'h0 : rf[r1];
      er = ui ? im : ((SKIP && r2 == 5'd0) ? 32'h0 : rf[r2]);
      run_req(r1, r2, im, ui, 3'($urandom), int'($urandom_range(0, 3)), el, er, ui ? 3 : 4, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvm_operand_fetch.md
Name: rvm_operand_fetch

Overview:
- Upstream feeder for the 32-bit add/subtract/compare unit.
- Accepts a decoded ALU request (rs1, rs2, immediate, op) and sequences the two source-register reads through the single synchronous read port of the register file.
- Presents registered lhs/rhs/op to the arithmetic unit behind a valid/ready handshake.
- One request in flight at a time, matching the multi-cycle core.

Parameters:
- REG_AW, 5, register address width (32 architectural registers).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  decoder presents a request.
- req_ready  output  1  block can accept a request (IDLE only).
- req_rs1  input  REG_AW  source register 1 address.
- req_rs2  input  REG_AW  source register 2 address.
- req_imm  input  32  sign-extended immediate.
- req_use_imm  input  1  1: rhs = req_imm, rs2 not read.
- req_op  input  3  arithmetic op code, passed through unmodified (NOP/ADD/SUB/GE/GEU/LT/LTU encodings).
- rf_rd_en  output  1  register file read strobe.
- rf_rd_addr  output  REG_AW  register file read address.
- rf_rd_data  input  32  read data; valid exactly one cycle after the rf_rd_en cycle.
- out_valid  output  1  operands stable for the arithmetic unit.
- out_ready  input  1  consumer has taken the operands.
- out_lhs  output  32  left operand.
- out_rhs  output  32  right operand.
- out_op  output  3  latched op code.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - state = IDLE; out_valid = 0; rf_rd_en = 0.
  - rf_rd_addr = 0; out_lhs = 0; out_rhs = 0; out_op = 3'b000.
  - Latched request fields = 0.
- States: IDLE, RS1, RS2, OUT.
- IDLE:
  - req_ready = 1.
  - req_valid=1: latch rs1, rs2, imm, use_imm, op; go RS1.
  - req_valid=0: stay IDLE.
- RS1 (one cycle):
  - rf_rd_en = 1, rf_rd_addr = latched rs1; go RS2.
- RS2 (one cycle):
  - out_lhs <= rf_rd_data (rs1 value).
  - use_imm=1: rf_rd_en = 0; out_rhs <= latched imm; out_op <= op; go OUT.
  - use_imm=0: rf_rd_en = 1, rf_rd_addr = latched rs2; go internal sub-cycle CAP, then OUT.
- CAP (one cycle, use_imm=0 only):
  - rf_rd_en = 0; out_rhs <= rf_rd_data (rs2 value); out_op <= op; go OUT.
- OUT:
  - out_valid = 1; out_lhs/out_rhs/out_op held stable.
  - out_ready=1 in same cycle: go IDLE, out_valid drops next cycle.
  - out_ready=0: stay OUT indefinitely.
- Latency, request accept edge to first out_valid cycle:
  - Register-register: 4 cycles (IDLE accept, RS1, RS2, CAP, OUT).
  - Register-immediate: 3 cycles.
- Handshakes:
  - req_ready = 0 in every state except IDLE; req_valid outside IDLE is ignored and not latched.
  - No accept/emit overlap: new request accepted no earlier than the cycle after the out_valid&out_ready handshake.
- Outputs:
  - rf_rd_en/rf_rd_addr are registered outputs of the FSM, glitch-free.
  - rf_rd_addr holds its last value when rf_rd_en = 0.
- Arithmetic/width: no arithmetic performed; data passed bit-exact, no sign/zero extension beyond req_imm as given.
- Same-register reads: rs1 == rs2 still performs two reads.
- x0: without the optional feature, x0 is read from the register file (file returns zero).
- Reset mid-operation: any state returns to IDLE immediately.
  - out_valid and rf_rd_en deassert asynchronously.
  - The in-flight request is discarded.
- op = NOP is forwarded normally; the consumer treats it as invalid.

Optional Feature:
- Macro: RVM_FETCH_X0_SKIP_EN.
- Defined: when a latched source address is 0, its read cycle keeps identical timing but rf_rd_en = 0 for that cycle, and the corresponding operand captures 32'h0 instead of rf_rd_data (power saving, no dependence on register file x0 behaviour).
- Undefined: x0 is read like any other register.
- Latency identical in both builds.

Test Plan:
- Reset asserted mid-RS2 with rs1=3, rs2=4 -> out_valid=0 and rf_rd_en=0 immediately; state IDLE, req_ready=1 after release.
- RF x5=0x0000_0010, x6=0xFFFF_FFF0; request rs1=5, rs2=6, use_imm=0, op=ADD -> read x5 then x6 on consecutive cycles; out_valid 4 cycles after accept with lhs=0x10, rhs=0xFFFF_FFF0, op=ADD.
- rs1=7 (0x1234_5678), imm=0xFFFF_F800, use_imm=1, op=SUB -> single read; out_valid 3 cycles after accept with rhs=0xFFFF_F800.
- Hold out_ready=0 for 10 cycles in OUT, toggle req_valid -> outputs stable, req_ready=0, no new latch; out_ready=1 -> IDLE next cycle, next request accepted.
- rs1=rs2=9 (0xA5A5_A5A5), op=LTU -> two reads of address 9; lhs=rhs=0xA5A5_A5A5.
- With RVM_FETCH_X0_SKIP_EN, rs1=0, rs2=2, RF driving 0xDEAD_BEEF on rf_rd_data for the rs1 cycle -> no rf_rd_en for rs1, lhs=0; latency still 4.
